// File: rtl/tia_player_scan_counter.sv
// TIA player horizontal position counter and graphics scan sequencer.
// A 160-clock position counter generates copy start events; each copy scans
// the eight graphics bits at 1, 2 or 4 motion clocks per bit.
`timescale 1ns/1ps
module tia_player_scan_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       motck,
    input  logic       resp,
    input  logic [2:0] nusiz,
    input  logic       reflect,
    output logic       gs0,
    output logic       gs1,
    output logic       gs2,
    output logic       active,
    output logic [7:0] count
);

    logic [7:0] count_q, count_d, count_inc;
    logic       active_q, active_d;
    logic [2:0] idx_q, idx_d;
    logic [1:0] sub_q, sub_d;
    // Width stored as clocks-per-bit minus one: 0, 1 or 3.
    logic [1:0] wm1_q, wm1_d;
    logic [1:0] wm1_new;
    logic       extra_hit;
    logic       start;
    logic [2:0] gs;

    // Counter increment value and copy-start decode for the next count.
    always_comb begin
        count_inc = (count_q == 8'd159) ? 8'd0 : count_q + 8'd1;
        extra_hit = 1'b0;
        unique case (nusiz)
            3'b001:  extra_hit = (count_inc == 8'd16);
            3'b010:  extra_hit = (count_inc == 8'd32);
            3'b011:  extra_hit = (count_inc == 8'd16) || (count_inc == 8'd32);
            3'b100:  extra_hit = (count_inc == 8'd64);
            3'b110:  extra_hit = (count_inc == 8'd32) || (count_inc == 8'd64);
            default: extra_hit = 1'b0;
        endcase
        // Only an increment can start a copy; a resp load to 0 never does.
        start = motck && !resp && ((count_q == 8'd159) || extra_hit);
        unique case (nusiz)
            3'b101:  wm1_new = 2'd1;
            3'b111:  wm1_new = 2'd3;
            default: wm1_new = 2'd0;
        endcase
    end

    // Next-state for the position counter and the bit scan.
    always_comb begin
        count_d  = count_q;
        active_d = active_q;
        idx_d    = idx_q;
        sub_d    = sub_q;
        wm1_d    = wm1_q;

        if (resp) begin
            count_d = 8'd0;
        end else if (motck) begin
            count_d = count_inc;
        end

        // resp leaves the scan alone so an in-progress copy completes.
        if (start) begin
            active_d = 1'b1;
            idx_d    = 3'd0;
            sub_d    = 2'd0;
            wm1_d    = wm1_new;
        end else if (motck && active_q) begin
            if (sub_q == wm1_q) begin
                sub_d = 2'd0;
                if (idx_q == 3'd7) begin
                    active_d = 1'b0;
                    idx_d    = 3'd0;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end else begin
                sub_d = sub_q + 2'd1;
            end
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= 8'd0;
            active_q <= 1'b0;
            idx_q    <= 3'd0;
            sub_q    <= 2'd0;
            wm1_q    <= 2'd0;
        end else begin
            count_q  <= count_d;
            active_q <= active_d;
            idx_q    <= idx_d;
            sub_q    <= sub_d;
            wm1_q    <= wm1_d;
        end
    end

    // Bit select follows the live reflect input; D7 first when not reflected.
    always_comb begin
        gs     = reflect ? idx_q : (3'd7 - idx_q);
        gs0    = gs[0];
        gs1    = gs[1];
        gs2    = gs[2];
        active = active_q;
        count  = count_q;
    end

endmodule

// File: tb/tb_tia_player_scan_counter.sv
// Scoreboard bench: stimulus pushes expected post-edge outputs, a monitor
// pops and compares one entry after every rising edge.
`timescale 1ns/1ps
module tb_tia_player_scan_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       motck = 1'b0;
    logic       resp = 1'b0;
    logic [2:0] nusiz = 3'd0;
    logic       reflect = 1'b0;
    logic       gs0, gs1, gs2, active;
    logic [7:0] count;

    always #5 clk = ~clk;

    tia_player_scan_counter dut (
        .clk     (clk),
        .reset   (reset),
        .motck   (motck),
        .resp    (resp),
        .nusiz   (nusiz),
        .reflect (reflect),
        .gs0     (gs0),
        .gs1     (gs1),
        .gs2     (gs2),
        .active  (active),
        .count   (count)
    );

    typedef struct {
        int    count;
        int    active;
        int    gs;
        string tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Expected behaviour expressed as elapsed motion clocks since copy start.
    int         ec = 0;
    int         elapsed = 0;
    int         mw = 1;
    bit         ma = 1'b0;
    logic [2:0] cfg_nusiz = 3'd0;
    logic       cfg_reflect = 1'b0;
    string      tag = "init";

    function automatic int width_of(input logic [2:0] n);
        if (n == 3'b101) return 2;
        if (n == 3'b111) return 4;
        return 1;
    endfunction

    function automatic bit extra_start(input logic [2:0] n, input int c);
        case (n)
            3'b001:  return c == 16;
            3'b010:  return c == 32;
            3'b011:  return c == 16 || c == 32;
            3'b100:  return c == 64;
            3'b110:  return c == 32 || c == 64;
            default: return 1'b0;
        endcase
    endfunction

    task automatic step(input logic mo, input logic rp, input logic rs);
        exp_t e;
        int   nc;
        int   ix;
        bit   st;
        @(negedge clk);
        reset   = rs;
        motck   = mo;
        resp    = rp;
        nusiz   = cfg_nusiz;
        reflect = cfg_reflect;
        if (rs) begin
            ec = 0; ma = 1'b0; elapsed = 0; mw = 1;
        end else begin
            nc = (ec == 159) ? 0 : ec + 1;
            st = mo && !rp && (nc == 0 || extra_start(cfg_nusiz, nc));
            if (rp) ec = 0;
            else if (mo) ec = nc;
            if (st) begin
                ma = 1'b1; elapsed = 0; mw = width_of(cfg_nusiz);
            end else if (mo && ma) begin
                elapsed++;
                if (elapsed == 8 * mw) begin
                    ma = 1'b0; elapsed = 0;
                end
            end
        end
        ix = ma ? elapsed / mw : 0;
        e.count  = ec;
        e.active = ma ? 1 : 0;
        e.gs     = cfg_reflect ? ix : 7 - ix;
        e.tag    = tag;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input string t, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s [%s] actual=%0d expected=%0d at %0t", name, t, act, req, $time);
        end
    endtask

    // Monitor: one expected entry per rising edge, compared 1ns after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("count", e.tag, int'(count), e.count);
                chk("active", e.tag, int'(active), e.active);
                chk("gs", e.tag, int'({gs2, gs1, gs0}), e.gs);
            end
        end
    end

    initial begin
        // Reset state with both reflect settings, resp/motck ignored.
        tag = "reset";
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        cfg_reflect = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        cfg_reflect = 1'b0;

        // Single copy: first copy only after the first wrap, then every 160.
        tag = "nusiz000";
        step(1'b0, 1'b0, 1'b1);
        repeat (330) step(1'b1, 1'b0, 1'b0);

        tag = "nusiz011";
        cfg_nusiz = 3'b011;
        step(1'b0, 1'b0, 1'b1);
        repeat (200) step(1'b1, 1'b0, 1'b0);

        tag = "nusiz110";
        cfg_nusiz = 3'b110;
        step(1'b0, 1'b0, 1'b1);
        repeat (100) step(1'b1, 1'b0, 1'b0);

        // Quad width, reflected, motck toggling so holds are exercised.
        tag = "quad";
        cfg_nusiz = 3'b111;
        cfg_reflect = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 400; i++) step((i % 2) == 0, 1'b0, 1'b0);

        // resp at count 80 kills the main copy but not the copy at 16.
        tag = "resp80";
        cfg_nusiz = 3'b001;
        cfg_reflect = 1'b0;
        step(1'b0, 1'b0, 1'b1);
        repeat (240) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        repeat (200) step(1'b1, 1'b0, 1'b0);

        // resp at idx 3: copy runs to the end, count restarts.
        tag = "respmid";
        cfg_nusiz = 3'b000;
        step(1'b0, 1'b0, 1'b1);
        repeat (163) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        repeat (10) step(1'b1, 1'b0, 1'b0);

        // Reset at idx 5 of a double-width copy, with resp and motck high.
        tag = "rstmid";
        cfg_nusiz = 3'b101;
        step(1'b0, 1'b0, 1'b1);
        repeat (170) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        repeat (5) step(1'b1, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d pending expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tia_player_scan_counter.md
TIA_PLAYER_SCAN_COUNTER -- requirements
Module: tia_player_scan_counter

Interface
REQ-001 Parameters: none; the line length is fixed at 160 color clocks and copy offsets are fixed at 16/32/64.
REQ-002 clk  input  1  single system clock; all state changes on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 motck  input  1  motion clock enable; counter and scan advance only on clk edges with motck=1.
REQ-005 resp  input  1  RESPx strobe; repositions the player.
REQ-006 nusiz  input  3  NUSIZx number/size code (bits 2:0).
REQ-007 reflect  input  1  REFPx; reverses bit order.
REQ-008 gs0, gs1, gs2  output  1 each  bit select feeding the player graphics register; gs0 is the LSB.
REQ-009 active  output  1  high while a copy is being drawn; gates the graphics-register new/old outputs.
REQ-010 count  output  8  position counter value, 0..159.

Function
REQ-011 Position counter: on clk with motck=1 and resp=0, count <= (count==159) ? 0 : count+1.
REQ-012 resp=1 on a clk edge: count <= 0 regardless of motck; no start event is generated on that edge.
REQ-013 Start event: count reaches a start value by increment on a motck edge; a load by resp never generates a start event.
REQ-014 Main copy start: 159->0 wrap, for every nusiz.
REQ-015 Extra copy starts by nusiz:
- 000, 101, 111: none
- 001: 16
- 010: 32
- 011: 16, 32
- 100: 64
- 110: 32, 64
REQ-016 Width by nusiz: 101 = 2 clocks/bit; 111 = 4 clocks/bit; all other codes = 1 clock/bit.
REQ-017 Width is latched on the start-event edge and held for the whole copy.
REQ-018 Scan state: active, bit index idx[2:0], sub-count sub[1:0].
REQ-019 On the start-event edge: active <= 1, idx <= 0, sub <= 0. The first pixel is visible in the cycle after the edge (latency 1 clk).
REQ-020 On each motck edge while active with no start event:
- if sub == width-1: sub <= 0 and idx <= idx+1
- otherwise: sub <= sub+1
REQ-021 End of copy: at idx==7 with sub==width-1 on a motck edge, active <= 0 and idx <= 0.
- Copy length is exactly 8*width motck edges.
REQ-022 A start event while active restarts the scan: idx=0, sub=0, new width latched. It does not extend or merge with the previous copy.
REQ-023 resp does not affect active, idx or sub; an in-progress copy completes.
REQ-024 motck=0: all state holds; outputs are stable.
REQ-025 gs[2:0] is combinational from idx and the live reflect input:
- reflect=0: gs = 7 - idx (D7 drawn first)
- reflect=1: gs = idx
REQ-026 When active=0, gs follows the same mapping (idx=0); the consumer uses active to suppress pixels.
REQ-027 Simultaneous resp and motck: resp wins (REQ-012); the counter does not increment on that edge.

Reset
REQ-028 reset=1 on a clk edge: count=0, active=0, idx=0, sub=0, latched width=1.
- gs = 3'b111 when reflect=0; gs = 3'b000 when reflect=1.
REQ-029 Reset has priority over resp, motck and start events.
REQ-030 Reset mid-copy aborts the copy immediately; active=0 on the next cycle.
REQ-031 After reset is released with count=0, no start event occurs until the next 159->0 wrap.

Verification
REQ-032 nusiz=000, motck=1 continuous, reset released: active first rises the cycle after the 159->0 wrap. gs sequence over 8 cycles is 7,6,5,4,3,2,1,0, then active=0. Repeats every 160 cycles.
REQ-033 nusiz=011: copies start at counts 0, 16 and 32. Each copy is 8 cycles with active high; active is low for counts 8-15, 24-31 and 40-159.
REQ-034 nusiz=111, reflect=1: active is high for 32 motck edges. gs holds each of 0..7 for 4 edges; with motck toggling 1,0,1,0 the copy takes 64 clk cycles and gs never changes on motck=0 edges.
REQ-035 resp asserted at count=80 with motck=1 and nusiz=001:
- count=0 on the next cycle
- no main copy is drawn
- the copy at count 16 is drawn normally
- the next main copy starts after count 159
REQ-036 resp asserted at idx=3 of a copy: the copy continues through idx=7 unchanged and count restarts at 0.
REQ-037 reset asserted at idx=5 of a 2x copy: active=0, idx=0 and count=0 the next cycle; reset takes priority even with resp=1 and motck=1 on the same edge.
